// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage (zero/sign/upper/branch) with valid/ready on both sides.
// Define IMMEXT_SKID_EN to add a skid register and a registered in_ready.
//
// state | meaning
// EMPTY | no result held, out_valid=0
// ONE   | main register holds the oldest result
// TWO   | main and skid both full, input refused (IMMEXT_SKID_EN only)
module imm_ext_stage #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] main_data;
    logic [1:0]       main_mode;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        sext     = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
        ext_data = '0;
        case (in_mode)
            2'd0:    ext_data = {{PAD_W{1'b0}}, in_imm};
            2'd1:    ext_data = sext;
            2'd2:    ext_data = {in_imm, {PAD_W{1'b0}}};
            default: ext_data = sext << BR_SHIFT;
        endcase
    end

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_data  = main_data;
    assign out_mode  = main_mode;

`ifdef IMMEXT_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t             state;
    logic [OUT_W-1:0] skid_data;
    logic [1:0]       skid_mode;

    // in_ready depends only on registered state, so out_ready never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_data <= '0;
            main_mode <= 2'd0;
            skid_data <= '0;
            skid_mode <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_data <= ext_data;
                        main_mode <= in_mode;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_data <= ext_data;
                        main_mode <= in_mode;
                    end else if (in_xfer) begin
                        skid_data <= ext_data;
                        skid_mode <= in_mode;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_data <= skid_data;
                        main_mode <= skid_mode;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`else

    typedef enum logic {
        EMPTY = 1'b0,
        ONE   = 1'b1
    } occ_t;

    occ_t state;

    assign in_ready = !out_valid || out_ready;

    // In ONE an input transfer implies out_ready, so main is simply replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            main_data <= '0;
            main_mode <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_data <= ext_data;
                        main_mode <= in_mode;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    if (in_xfer) begin
                        main_data <= ext_data;
                        main_mode <= in_mode;
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// Directed-vector and scoreboard bench for imm_ext_stage (IN_W=16, OUT_W=32, BR_SHIFT=2).
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;

    int checks = 0;
    int errors = 0;

`ifdef IMMEXT_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    imm_ext_stage #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] s;
        logic [31:0] r;
        s = {{16{imm[15]}}, imm};
        case (mode)
            2'd0:    r = {16'h0000, imm};
            2'd1:    r = s;
            2'd2:    r = {imm, 16'h0000};
            default: r = {s[29:0], 2'b00};
        endcase
        return {mode, r};
    endfunction

    // Scoreboard monitor: inputs change just after posedge, so negedge sees what the next edge will act on.
    logic        mon_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_mode;
    logic [33:0] sb[$];
    logic [31:0] got[$];

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && $isunknown(out_data))
                chk("x_on_out_data", 32'd1, 32'd0);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_mode", {30'd0, out_mode}, {30'd0, prev_mode});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    logic [33:0] e;
                    e = sb.pop_front();
                    chk("sb_data", out_data, e[31:0]);
                    chk("sb_mode", {30'd0, out_mode}, {30'd0, e[33:32]});
                end
                got.push_back(out_data);
            end
            if (in_valid && in_ready)
                sb.push_back(model(in_imm, in_mode));
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_mode  = out_mode;
        end else begin
            prev_stall = 1'b0;
            sb.delete();
            got.delete();
        end
    end

    initial begin
        int idx;
        int n_sent;

        vecs[0] = '{16'h8001, 2'd0, 32'h00008001};
        vecs[1] = '{16'h8001, 2'd1, 32'hFFFF8001};
        vecs[2] = '{16'h7FFF, 2'd1, 32'h00007FFF};
        vecs[3] = '{16'h1234, 2'd2, 32'h12340000};
        vecs[4] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        vecs[5] = '{16'h0003, 2'd3, 32'h0000000C};
        vecs[6] = '{16'h8000, 2'd3, 32'hFFFE0000};
        vecs[7] = '{16'hABCD, 2'd0, 32'h0000ABCD};
        vecs[8] = '{16'hABCD, 2'd2, 32'hABCD0000};
        vecs[9] = '{16'h4000, 2'd3, 32'h00010000};

        rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_out_mode", {30'd0, out_mode}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // One vector at a time, out_ready high: result must appear exactly one edge after acceptance.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_before_vec", {31'd0, out_valid}, 32'd0);
            in_valid = 1'b1; in_imm = vecs[i].imm; in_mode = vecs[i].mode; out_ready = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            chk($sformatf("vec%0d_mode", i), {30'd0, out_mode}, {30'd0, vecs[i].mode});
        end
        @(posedge clk); #1;

        // Backpressure: offer 1,2,3 in mode 0 with out_ready low.
        mon_en = 1'b1;
        out_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid = (idx <= 3); in_imm = 16'(idx); in_mode = 2'd0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
        end
        chk("bp_accepted", 32'(idx - 1), 32'(EXP_ACC));
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_data", out_data, 32'h00000001);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = (idx <= 3); in_imm = 16'(idx); in_mode = 2'd0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
        end
        chk("bp_out_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("bp_out0", got[0], 32'h00000001);
            chk("bp_out1", got[1], 32'h00000002);
            chk("bp_out2", got[2], 32'h00000003);
        end
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while holding entries: everything must clear at once.
        @(posedge clk); #1;
        mon_en = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_imm = 16'h5A5A; in_mode = 2'd2;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_reset_mode", {30'd0, out_mode}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_mode", {30'd0, out_mode}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_empty", {31'd0, out_valid}, 32'd0);

        // Random streaming against the scoreboard.
        @(negedge clk);
        mon_en = 1'b1;
        n_sent = 0;
        for (int c = 0; c < 2000; c++) begin
            if (n_sent >= 100 && sb.size() == 0 && !out_valid) break;
            @(posedge clk); #1;
            in_valid  = (n_sent < 100) && ($urandom_range(0, 1) == 1);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (in_valid && in_ready) n_sent++;
        end
        chk("stream_sent", 32'(n_sent), 32'd100);
        chk("stream_received", 32'(got.size()), 32'd100);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, pipelined immediate-extension stage for the CPU datapath. It takes an IN_W-bit instruction immediate and a 2-bit mode, and produces an OUT_W-bit operand: zero-extended, sign-extended, upper-placed (LUI), or sign-extended and shifted (branch offset). The stage sits between decode and the ALU/branch-target operand muxes. It is registered, with a valid/ready handshake on both sides.

## Interface
Parameters:
- IN_W, 16, immediate input width
- OUT_W, 32, output width; must satisfy OUT_W > IN_W
- BR_SHIFT, 2, left shift applied in mode 3; must satisfy BR_SHIFT < OUT_W

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an immediate
- in_ready  out  1  stage can accept this cycle
- in_imm  in  IN_W  raw immediate
- in_mode  in  2  0 zero-ext, 1 sign-ext, 2 upper, 3 sign-ext then shift left by BR_SHIFT
- out_valid  out  1  out_data holds a result
- out_ready  in  1  downstream consumes this cycle
- out_data  out  OUT_W  extended immediate
- out_mode  out  2  mode that produced out_data, for downstream mux select

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready at a rising edge.
- Extension is computed combinationally from in_imm/in_mode and captured on input transfer:
  - mode 0: {(OUT_W-IN_W) zeros, in_imm}.
  - mode 1: {(OUT_W-IN_W) copies of in_imm[IN_W-1], in_imm}.
  - mode 2: in_imm in the top IN_W bits, zeros below. Lower field width is OUT_W-IN_W.
  - mode 3: mode-1 result << BR_SHIFT, truncated to OUT_W. Shifted-out MSBs are discarded and vacated LSBs are zero.
- Storage is a main output register. With IMMEXT_SKID_EN it is backed by one skid register. Order is strictly FIFO.
- Occupancy states: EMPTY (out_valid=0), ONE (main full), TWO (main and skid full; skid build only).
  - EMPTY + in xfer → ONE.
  - ONE + in xfer without out xfer → TWO.
  - ONE + out xfer without in xfer → EMPTY.
  - ONE + both → ONE, main takes the new data.
  - TWO + out xfer → ONE, skid moves to main.
  - TWO accepts no input.
- out_data and out_mode are held stable while out_valid && !out_ready.
- in_imm and in_mode are don't-care when in_valid=0. No X may reach out_data when out_valid=1.

## Timing
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, out_mode=0, skid cleared, in_ready=1.
  - Deassertion is taken synchronously on the next edge by the surrounding reset synchroniser.
  - Reset mid-operation drops all held entries. No partial output.
- Latency: exactly 1 cycle. An input accepted at edge N has out_valid=1 after edge N, when the stage was EMPTY or passed through.
- Throughput: 1 per cycle when out_ready is held high.
- in_ready with skid: registered, equal to (state != TWO). It has no combinational path from out_ready.
- in_ready without skid: combinational, equal to !out_valid || out_ready.
- Simultaneous in and out transfer in ONE: occupancy unchanged, no bubble.

## Configuration
- IMMEXT_SKID_EN defined:
  - skid register present, in_ready registered.
  - up to 2 entries held; timing path out_ready→in_ready is broken.
- IMMEXT_SKID_EN undefined:
  - single register, in_ready combinational as above.
  - TWO state is unreachable and removed.
  - Data function and latency are identical.

## Test plan
(All cases use IN_W=16, OUT_W=32, BR_SHIFT=2.)
- Reset: drive rst_n low mid-stream with 2 entries held → out_valid=0, out_data=0x00000000 immediately, in_ready=1.
- Modes 0/1 with in_imm=0x8001, out_ready=1:
  - mode 0 → 0x00008001, one cycle later.
  - mode 1 → 0xFFFF8001.
  - mode 1 with 0x7FFF → 0x00007FFF.
- Modes 2/3:
  - mode 2 with 0x1234 → 0x12340000.
  - mode 3 with 0xFFFF → 0xFFFFFFFC.
  - mode 3 with 0x0003 → 0x0000000C.
  - out_mode matches the input mode in every case.
- Backpressure: out_ready=0 while offering 0x0001, 0x0002, 0x0003 back-to-back in mode 0.
  - With skid: 2 accepted, then in_ready=0. Release out_ready → outputs 0x00000001, 0x00000002, then 0x00000003, in order.
  - Without skid: 1 accepted.
  - out_data stable while stalled in both builds.
- Streaming: 100 random in_imm/in_mode values, with in_valid and out_ready each random at 50%.
  - Scoreboard matches the mode equations.
  - No loss or duplication; zero X on out_data while out_valid=1.
